// File: rtl/noc_packet_sink.sv
// noc_packet_sink
// Terminal NoC endpoint. It accepts flits through a valid/ready handshake,
// checks packet framing, and buffers well-framed flits in a first-word-fall-through
// FIFO for a downstream consumer. Mis-framed flits are handshaken and then dropped.
// It also keeps packet and error counters, a sticky misroute flag, and the
// source coordinates of the last header it buffered.
//
// Ports
//   noc_clk                      sole clock, rising edge
//   noc_rst                      synchronous active-high reset
//   in_valid / in_ready          upstream handshake
//   in_flit, in_is_header/tail   upstream flit and framing markers
//   out_valid / out_ready        downstream handshake
//   out_flit, out_is_header/tail head FIFO entry (don't-care while !out_valid)
//   pkt_count                    complete packets accepted (saturating)
//   err_count                    framing errors (saturating)
//   misroute                     sticky: a header with a foreign destination was buffered
//   last_src_x / last_src_y      source of the last buffered header
//
// Framing FSM
//   state       | meaning
//   EXPECT_HEAD | between packets; only a header is legal
//   IN_PACKET   | header seen; body/tail legal, another header is an error

`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 24
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 32
`endif

module noc_packet_sink #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID       = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID       = '0,
    parameter int unsigned                FIFO_DEPTH = 4
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`Noc_Data_Width-1:0] in_flit,
    input  logic                       in_is_header,
    input  logic                       in_is_tail,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`Noc_Data_Width-1:0] out_flit,
    output logic                       out_is_header,
    output logic                       out_is_tail,
    output logic [7:0]                 pkt_count,
    output logic [7:0]                 err_count,
    output logic                       misroute,
    output logic [`Noc_ID_X_Width-1:0] last_src_x,
    output logic [`Noc_ID_Y_Width-1:0] last_src_y
);

    localparam int unsigned XW      = `Noc_ID_X_Width;
    localparam int unsigned YW      = `Noc_ID_Y_Width;
    localparam int unsigned ID_W    = XW + YW;
    localparam int unsigned DW      = `Noc_Data_Width;
    localparam int unsigned ENTRY_W = DW + 2;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W   = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic {
        EXPECT_HEAD = 1'b0,
        IN_PACKET   = 1'b1
    } state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [OCC_W-1:0]   occupancy;
    state_t             state;

    logic               push;
    logic               pop;
    logic               write_en;
    logic               pkt_done;
    logic               drop;
    logic [ID_W-1:0]    src_field;
    logic [ID_W-1:0]    dst_field;

    // Handshake flags depend only on registered occupancy.
    assign in_ready  = (occupancy != OCC_FULL);
    assign out_valid = (occupancy != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign {out_is_header, out_is_tail, out_flit} = mem[rd_ptr];

    assign src_field = in_flit[`Noc_Point_H-1:`Noc_Source_Point];
    assign dst_field = in_flit[`Noc_Source_Point-1 -: ID_W];

    // Decide what a handshaken flit does in the current framing state.
    always_comb begin
        write_en = 1'b0;
        pkt_done = 1'b0;
        if (push) begin
            unique case (state)
                EXPECT_HEAD: begin
                    write_en = in_is_header;
                    pkt_done = in_is_header && in_is_tail;
                end
                IN_PACKET: begin
                    write_en = !in_is_header;
                    pkt_done = !in_is_header && in_is_tail;
                end
                default: ;
            endcase
        end
    end

    assign drop = push && !write_en;

    // Storage has no reset; occupancy alone defines which entries are valid.
    always_ff @(posedge noc_clk) begin
        if (write_en && !noc_rst) begin
            mem[wr_ptr] <= {in_is_header, in_is_tail, in_flit};
        end
    end

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            state      <= EXPECT_HEAD;
            pkt_count  <= '0;
            err_count  <= '0;
            misroute   <= 1'b0;
            last_src_x <= '0;
            last_src_y <= '0;
        end else begin
            if (write_en && !pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (!write_en && pop) begin
                occupancy <= occupancy - OCC_W'(1);
            end

            // Power-of-two depth: pointer overflow is the modulo wrap.
            if (write_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if (push) begin
                unique case (state)
                    EXPECT_HEAD: if (in_is_header && !in_is_tail) state <= IN_PACKET;
                    IN_PACKET:   if (!in_is_header && in_is_tail) state <= EXPECT_HEAD;
                    default:     state <= EXPECT_HEAD;
                endcase
            end

            if (pkt_done && (pkt_count != 8'hFF)) begin
                pkt_count <= pkt_count + 8'd1;
            end
            if (drop && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end

            if (write_en && in_is_header) begin
                last_src_x <= src_field[ID_W-1:YW];
                last_src_y <= src_field[YW-1:0];
                if (dst_field != {X_ID, Y_ID}) begin
                    misroute <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/noc_packet_sink.md
NOC_PACKET_SINK -- requirements
Module: noc_packet_sink

Interface
REQ-001 SHALL have parameter X_ID, default 0, own X coordinate (`Noc_ID_X_Width bits).
REQ-002 SHALL have parameter Y_ID, default 0, own Y coordinate (`Noc_ID_Y_Width bits).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, flit buffer entries (power of 2, >=2).
REQ-004 SHALL have port noc_clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port noc_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  upstream flit valid.
REQ-007 SHALL have port in_ready  output  1  sink can accept a flit.
REQ-008 SHALL have port in_flit  input  `Noc_Data_Width  upstream flit.
REQ-009 SHALL have ports in_is_header / in_is_tail  input  1 each  flit framing markers.
REQ-010 SHALL have port out_valid  output  1  buffered flit available downstream.
REQ-011 SHALL have port out_ready  input  1  downstream accepts flit.
REQ-012 SHALL have ports out_flit (`Noc_Data_Width), out_is_header (1), out_is_tail (1)  output  head FIFO entry.
REQ-013 SHALL have port pkt_count  output  8  complete packets accepted.
REQ-014 SHALL have port err_count  output  8  framing errors.
REQ-015 SHALL have port misroute  output  1  sticky: header with destination != (X_ID,Y_ID) seen.
REQ-016 SHALL have ports last_src_x (`Noc_ID_X_Width), last_src_y (`Noc_ID_Y_Width)  output  source of last accepted header.

Function
REQ-017 Input transfer SHALL occur on a cycle with in_valid && in_ready; output transfer on out_valid && out_ready.
REQ-018 in_ready SHALL equal (occupancy != FIFO_DEPTH), derived from registered occupancy only, no dependency on in_valid or out_ready.
REQ-019 FIFO SHALL be first-word-fall-through: out_valid = (occupancy != 0); out_flit/out_is_header/out_is_tail = head entry; entry stores flit plus both markers.
REQ-020 Simultaneous push and pop SHALL leave occupancy unchanged; a push when full is impossible (in_ready low); pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 Latency: flit accepted in cycle N SHALL appear on out_* in cycle N+1 when FIFO was empty.
REQ-022 Framing FSM SHALL have states EXPECT_HEAD and IN_PACKET, updated only on input transfers.
REQ-023 EXPECT_HEAD, header && !tail: write flit, go IN_PACKET.
REQ-024 EXPECT_HEAD, header && tail: write flit, stay EXPECT_HEAD, pkt_count+1.
REQ-025 EXPECT_HEAD, !header: drop flit (not written, still handshaken), err_count+1, stay.
REQ-026 IN_PACKET, tail && !header: write flit, go EXPECT_HEAD, pkt_count+1.
REQ-027 IN_PACKET, !header && !tail: write flit, stay.
REQ-028 IN_PACKET, header (any tail value): drop flit, err_count+1, stay IN_PACKET.
REQ-029 On every written header: source field = in_flit[`Noc_Point_H-1:`Noc_Source_Point], upper `Noc_ID_X_Width bits -> last_src_x, lower `Noc_ID_Y_Width bits -> last_src_y.
REQ-030 On every written header: destination field = the (`Noc_ID_X_Width+`Noc_ID_Y_Width) bits immediately below `Noc_Source_Point (X upper); mismatch with (X_ID,Y_ID) SHALL set misroute; flit still written.
REQ-031 pkt_count and err_count SHALL saturate at 255, no wrap.
REQ-032 Dropped flits SHALL not affect occupancy, last_src_*, or misroute.

Reset
REQ-033 With noc_rst high at a rising edge: occupancy 0, pointers 0, FSM EXPECT_HEAD, pkt_count 0, err_count 0, misroute 0, last_src_x/y 0; hence in_ready 1, out_valid 0.
REQ-034 Reset mid-packet SHALL discard all buffered flits and partial packet state; no flit accepted during the reset cycle is written.
REQ-035 out_flit/out_is_header/out_is_tail SHALL be don't-care while out_valid is 0.

Verification
REQ-036 3-flit packet (header src (1,2) dest (X_ID,Y_ID), data all-ones, tail), out_ready=1 -> same 3 flits out in order, each 1 cycle after input; pkt_count=1, last_src=(1,2), misroute=0.
REQ-037 out_ready=0, stream 6 flits, FIFO_DEPTH=4 -> in_ready low after 4th accept, occupancy 4; raise out_ready -> all 6 flits out in order, no loss or duplication.
REQ-038 Data flit while EXPECT_HEAD, then header inside a packet -> err_count=2, neither flit appears on out_*, following tail completes packet, pkt_count=1.
REQ-039 Header with dest != (X_ID,Y_ID) -> misroute=1, stays 1 after later correct packets; flit still forwarded.
REQ-040 300 header+tail single-flit packets -> pkt_count=255 (saturated); assert noc_rst mid-packet with 2 flits buffered -> next cycle out_valid=0, in_ready=1, all counters 0.
